// File: rtl/branch_forward_unit.sv
// branch_forward_unit
// ID-stage forwarding and hazard detection for the early branch comparator.
// Picks the youngest in-flight value for each branch source operand, raises
// a stall when the needed value is not yet available, and counts stall cycles.
// Optional build macro: BRANCH_FWD_STATS_EN adds fwdCountEX / fwdCountMEM
// statistics counters.
module branch_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_branch,
    input  logic [4:0]       IDEX_rd,
    input  logic             IDEX_regWrite,
    input  logic [4:0]       EXMEM_rd,
    input  logic             EXMEM_regWrite,
    input  logic             EXMEM_memRead,
    input  logic [4:0]       MEMWB_rd,
    input  logic             MEMWB_regWrite,
    output logic [1:0]       branchFWDA,
    output logic [1:0]       branchFWDB,
    output logic             branchStall,
`ifdef BRANCH_FWD_STATS_EN
    output logic [CNT_W-1:0] fwdCountEX,
    output logic [CNT_W-1:0] fwdCountMEM,
`endif
    output logic [CNT_W-1:0] stallCycles
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Operand select: EX/MEM holds the younger value so it wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (EXMEM_regWrite && (EXMEM_rd != 5'd0) && (EXMEM_rd == src)) begin
            return SEL_EX;
        end
        if (MEMWB_regWrite && (MEMWB_rd != 5'd0) && (MEMWB_rd == src)) begin
            return SEL_MEM;
        end
        return SEL_RF;
    endfunction

    logic             haz_ex;
    logic             haz_ld;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Forward selects and hazard flags, evaluated every cycle independent of reset.
    always_comb begin
        branchFWDA  = fwd_sel(IFID_rs);
        branchFWDB  = fwd_sel(IFID_rt);
        // An ALU result still in EX cannot be forwarded into ID this cycle.
        haz_ex      = IDEX_regWrite && (IDEX_rd != 5'd0) &&
                      ((IDEX_rd == IFID_rs) || (IDEX_rd == IFID_rt));
        // A load in MEM only has its data at WB, one cycle too late.
        haz_ld      = EXMEM_memRead && EXMEM_regWrite && (EXMEM_rd != 5'd0) &&
                      ((EXMEM_rd == IFID_rs) || (EXMEM_rd == IFID_rt));
        branchStall = IFID_branch && (haz_ex || haz_ld);
        stall_cnt_d = branchStall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // Stall-cycle counter; reset has priority over counting.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;

`ifdef BRANCH_FWD_STATS_EN
    logic [CNT_W-1:0] fwd_ex_q;
    logic [CNT_W-1:0] fwd_ex_d;
    logic [CNT_W-1:0] fwd_mem_q;
    logic [CNT_W-1:0] fwd_mem_d;

    // Statistics next-state: one count per edge if either operand uses the path.
    always_comb begin
        fwd_ex_d  = ((branchFWDA == SEL_EX) || (branchFWDB == SEL_EX)) ?
                    sat_inc(fwd_ex_q) : fwd_ex_q;
        fwd_mem_d = ((branchFWDA == SEL_MEM) || (branchFWDB == SEL_MEM)) ?
                    sat_inc(fwd_mem_q) : fwd_mem_q;
    end

    // Statistics counters, cleared by reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            fwd_ex_q  <= '0;
            fwd_mem_q <= '0;
        end else begin
            fwd_ex_q  <= fwd_ex_d;
            fwd_mem_q <= fwd_mem_d;
        end
    end

    assign fwdCountEX  = fwd_ex_q;
    assign fwdCountMEM = fwd_mem_q;
`endif

endmodule

// File: tb/tb_branch_forward_unit.sv
// Directed testbench for branch_forward_unit (counter width reduced to 4 so
// saturation is reachable in a few cycles).
module tb_branch_forward_unit;

    localparam int CNT_W = 4;

    logic             Clock;
    logic             Reset_n;
    logic [4:0]       IFID_rs;
    logic [4:0]       IFID_rt;
    logic             IFID_branch;
    logic [4:0]       IDEX_rd;
    logic             IDEX_regWrite;
    logic [4:0]       EXMEM_rd;
    logic             EXMEM_regWrite;
    logic             EXMEM_memRead;
    logic [4:0]       MEMWB_rd;
    logic             MEMWB_regWrite;
    logic [1:0]       branchFWDA;
    logic [1:0]       branchFWDB;
    logic             branchStall;
    logic [CNT_W-1:0] stallCycles;
`ifdef BRANCH_FWD_STATS_EN
    logic [CNT_W-1:0] fwdCountEX;
    logic [CNT_W-1:0] fwdCountMEM;
`endif

    int total;
    int bad;

    branch_forward_unit #(.CNT_W(CNT_W)) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .IFID_rs        (IFID_rs),
        .IFID_rt        (IFID_rt),
        .IFID_branch    (IFID_branch),
        .IDEX_rd        (IDEX_rd),
        .IDEX_regWrite  (IDEX_regWrite),
        .EXMEM_rd       (EXMEM_rd),
        .EXMEM_regWrite (EXMEM_regWrite),
        .EXMEM_memRead  (EXMEM_memRead),
        .MEMWB_rd       (MEMWB_rd),
        .MEMWB_regWrite (MEMWB_regWrite),
        .branchFWDA     (branchFWDA),
        .branchFWDB     (branchFWDB),
        .branchStall    (branchStall),
`ifdef BRANCH_FWD_STATS_EN
        .fwdCountEX     (fwdCountEX),
        .fwdCountMEM    (fwdCountMEM),
`endif
        .stallCycles    (stallCycles)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        IFID_rs        = 5'd0;
        IFID_rt        = 5'd0;
        IFID_branch    = 1'b0;
        IDEX_rd        = 5'd0;
        IDEX_regWrite  = 1'b0;
        EXMEM_rd       = 5'd0;
        EXMEM_regWrite = 1'b0;
        EXMEM_memRead  = 1'b0;
        MEMWB_rd       = 5'd0;
        MEMWB_regWrite = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_pipe();
        Reset_n = 1'b0;
        tick(2);
        chk("reset_cnt", 32'(stallCycles), 32'd0);
        Reset_n = 1'b1;

        // Both stages match, EX/MEM wins
        IFID_rs = 5'd1; IFID_rt = 5'd1;
        EXMEM_rd = 5'd1; EXMEM_regWrite = 1'b1;
        MEMWB_rd = 5'd1; MEMWB_regWrite = 1'b1;
        #1;
        chk("prio_A", 32'(branchFWDA), 32'd1);
        chk("prio_B", 32'(branchFWDB), 32'd1);

        // No writers
        EXMEM_regWrite = 1'b0; MEMWB_regWrite = 1'b0;
        #1;
        chk("norw_A", 32'(branchFWDA), 32'd0);
        chk("norw_B", 32'(branchFWDB), 32'd0);

        // Only MEM/WB matches
        EXMEM_rd = 5'd3; EXMEM_regWrite = 1'b1; MEMWB_regWrite = 1'b1;
        #1;
        chk("wb_A", 32'(branchFWDA), 32'd2);
        chk("wb_B", 32'(branchFWDB), 32'd2);

        // Register 0 never forwarded
        IFID_rs = 5'd0; IFID_rt = 5'd0; EXMEM_rd = 5'd0; MEMWB_rd = 5'd0;
        #1;
        chk("r0_A", 32'(branchFWDA), 32'd0);
        chk("r0_B", 32'(branchFWDB), 32'd0);

        // Only operand B matches EX/MEM
        IFID_rs = 5'd2; IFID_rt = 5'd5; EXMEM_rd = 5'd5; MEMWB_regWrite = 1'b0;
        #1;
        chk("split_A", 32'(branchFWDA), 32'd0);
        chk("split_B", 32'(branchFWDB), 32'd1);
        chk("split_nostall", 32'(branchStall), 32'd0);

        // Different sources on each operand
        IFID_rs = 5'd2; IFID_rt = 5'd6; EXMEM_rd = 5'd2;
        MEMWB_rd = 5'd6; MEMWB_regWrite = 1'b1;
        #1;
        chk("mix_A", 32'(branchFWDA), 32'd1);
        chk("mix_B", 32'(branchFWDB), 32'd2);

        // EX hazard on operand A
        clear_pipe();
        IFID_branch = 1'b1; IFID_rs = 5'd4; IFID_rt = 5'd9;
        IDEX_rd = 5'd4; IDEX_regWrite = 1'b1;
        #1;
        chk("exhaz_stall", 32'(branchStall), 32'd1);
        chk("exhaz_cnt0", 32'(stallCycles), 32'd0);
        tick(3);
        chk("exhaz_cnt3", 32'(stallCycles), 32'd3);

        IFID_branch = 1'b0;
        #1;
        chk("nobr_stall", 32'(branchStall), 32'd0);
        tick(1);
        chk("nobr_hold", 32'(stallCycles), 32'd3);

        IFID_branch = 1'b1; IDEX_regWrite = 1'b0;
        #1;
        chk("exnorw_stall", 32'(branchStall), 32'd0);
        IDEX_regWrite = 1'b1; IDEX_rd = 5'd0; IFID_rs = 5'd0;
        #1;
        chk("exr0_stall", 32'(branchStall), 32'd0);

        // Load-use hazard on operand B
        clear_pipe();
        IFID_branch = 1'b1; IFID_rs = 5'd3; IFID_rt = 5'd7;
        EXMEM_rd = 5'd7; EXMEM_regWrite = 1'b1; EXMEM_memRead = 1'b1;
        #1;
        chk("ld_stall", 32'(branchStall), 32'd1);
        chk("ld_fwdB", 32'(branchFWDB), 32'd1);
        EXMEM_regWrite = 1'b0;
        #1;
        chk("ld_norw_stall", 32'(branchStall), 32'd0);
        EXMEM_regWrite = 1'b1;
        tick(1);
        chk("ld_cnt4", 32'(stallCycles), 32'd4);

        // Reset mid-stall
        Reset_n = 1'b0;
        tick(1);
        chk("rst_cnt", 32'(stallCycles), 32'd0);
        chk("rst_comb_stall", 32'(branchStall), 32'd1);
        Reset_n = 1'b1;
        tick(1);
        chk("rst_resume", 32'(stallCycles), 32'd1);

        // Saturation
        tick(13);
        chk("sat_reach", 32'(stallCycles), 32'd14);
        tick(1);
        chk("sat_max", 32'(stallCycles), 32'd15);
        tick(3);
        chk("sat_hold", 32'(stallCycles), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
